// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode constants and sequencer FSM encoding shared with ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] c_OP_ADD  = 3'd0;
    localparam logic [2:0] c_OP_SUB  = 3'd1;
    localparam logic [2:0] c_OP_XOR  = 3'd2;
    localparam logic [2:0] c_OP_SLT  = 3'd3;
    localparam logic [2:0] c_OP_AND  = 3'd4;
    localparam logic [2:0] c_OP_NAND = 3'd5;
    localparam logic [2:0] c_OP_NOR  = 3'd6;
    localparam logic [2:0] c_OP_OR   = 3'd7;

    typedef enum logic [1:0] {
        c_ST_IDLE   = 2'd0,
        c_ST_SETTLE = 2'd1,
        c_ST_RESP   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer_if
//  Description : Request/response valid-ready channels of the ALU sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_overflow;
    logic        rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_zero
    );

endinterface
`default_nettype wire

// File: rtl/alu_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_settle_timer
//  Description : 8-bit counter flagging the last edge of the ALU settle window.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic start,
    output logic      done
);

    localparam logic [7:0] c_LAST = 8'(SETTLE_CYCLES - 1);

    logic [7:0] r_count;
    logic       r_running;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= 8'd0;
            r_running <= 1'b0;
        end else if (start) begin
            r_count   <= 8'd0;
            r_running <= 1'b1;
        end else if (r_running) begin
            if (r_count == c_LAST) begin
                r_running <= 1'b0;
            end else begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    // High during the cycle whose closing edge is the capture edge.
    assign done = r_running && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Launches handshaked requests into the combinational ALU and
//                returns registered results after a fixed settle window.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_sequencer_if.slave   bus,
    output logic [2:0]       alu_sel,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  wire logic [31:0] alu_result,
    input  wire logic        alu_carry,
    input  wire logic        alu_overflow,
    input  wire logic        alu_zero,
    output logic             busy
);

    state_t      r_state;
    logic        r_req_ready;
    logic        r_busy;
    logic [2:0]  r_alu_sel;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_result;
    logic        r_rsp_carry;
    logic        r_rsp_overflow;
    logic        r_rsp_zero;

    logic        w_start;
    logic        w_done;

    assign w_start = (r_state == c_ST_IDLE) && bus.req_valid;

    alu_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .done  (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_ST_IDLE;
            r_req_ready    <= 1'b1;
            r_busy         <= 1'b0;
            r_alu_sel      <= 3'd0;
            r_alu_a        <= 32'd0;
            r_alu_b        <= 32'd0;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= 32'd0;
            r_rsp_carry    <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_zero     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_alu_sel   <= bus.req_op;
                        r_alu_a     <= bus.req_a;
                        r_alu_b     <= bus.req_b;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= c_ST_SETTLE;
                    end
                end
                c_ST_SETTLE: begin
                    if (w_done) begin
                        r_rsp_result   <= alu_result;
                        r_rsp_carry    <= alu_carry;
                        r_rsp_overflow <= alu_overflow;
                        r_rsp_zero     <= alu_zero;
                        r_rsp_valid    <= 1'b1;
                        r_state        <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_result   = r_rsp_result;
    assign bus.rsp_carry    = r_rsp_carry;
    assign bus.rsp_overflow = r_rsp_overflow;
    assign bus.rsp_zero     = r_rsp_zero;
    assign alu_sel          = r_alu_sel;
    assign alu_a            = r_alu_a;
    assign alu_b            = r_alu_b;
    assign busy             = r_busy;

endmodule
`default_nettype wire
